// File: rtl/multi_ch_sampler.sv
// multi_ch_sampler: gated, decimated multi-channel capture into a FIFO, serialised as framed bytes to one tx_unit.
// Optional trailing XOR checksum byte when MULTI_CH_SAMPLER_CHECKSUM_EN is defined.
module multi_ch_sampler #(
    parameter int NUM_CH = 2,
    parameter int SAMPLE_SIZE = 14,
    parameter int TX_DATA_SIZE = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DECIM_WIDTH = 8,
    parameter logic [TX_DATA_SIZE-1:0] HEADER = 8'hA5
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_CH*SAMPLE_SIZE-1:0] i_data,
    input  logic                          i_gate,
    input  logic                          i_adc_init,
    input  logic [DECIM_WIDTH-1:0]        i_decim,
    input  logic                          i_next,
    output logic [TX_DATA_SIZE-1:0]       o_data,
    output logic                          o_valid,
    output logic                          o_overflow,
    output logic                          o_busy
);
    localparam int BPC = (SAMPLE_SIZE + TX_DATA_SIZE - 1) / TX_DATA_SIZE;
    localparam int NPAY = NUM_CH * BPC;
    localparam int CW = BPC * TX_DATA_SIZE;
    localparam int SRW = NPAY * TX_DATA_SIZE;
    localparam int DW = NUM_CH * SAMPLE_SIZE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(NPAY + 2);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t state, next_state;
    logic gate_m, gate_s, cap_en, tick, push, pop, empty, full, issue, last;
    logic [DECIM_WIDTH-1:0] cnt, lim;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] rd_word;
    logic [AW:0] wptr, rptr;
    logic [SRW-1:0] padded, sr;
    logic [IW-1:0] idx;
    logic [TX_DATA_SIZE-1:0] cur_byte;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            gate_m <= 1'b0;
            gate_s <= 1'b0;
        end else begin
            gate_m <= i_gate;
            gate_s <= gate_m;
        end
    end

    assign cap_en = gate_s & i_adc_init;
    assign tick = cap_en & (cnt == '0);

    // lim is reloaded only at a wrap so a new i_decim starts on a clean period
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
            lim <= '0;
        end else if (!cap_en || cnt == lim) begin
            cnt <= '0;
            lim <= i_decim;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop = state == LOAD;
    assign push = tick & (~full | pop);
    assign rd_word = mem[rptr[AW-1:0]];

    always_ff @(posedge i_clock) begin
        if (push) mem[wptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wptr <= '0;
            rptr <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (tick & full & ~pop) o_overflow <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pad
        assign padded[k*CW +: CW] = CW'(rd_word[k*SAMPLE_SIZE +: SAMPLE_SIZE]);
    end

`ifdef MULTI_CH_SAMPLER_CHECKSUM_EN
    localparam logic [IW-1:0] LAST = IW'(NPAY + 1);
    logic [TX_DATA_SIZE-1:0] csum;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) csum <= '0;
        else if (pop) csum <= '0;
        else if (issue && idx != '0 && idx != LAST) csum <= csum ^ sr[TX_DATA_SIZE-1:0];
    end

    assign cur_byte = (idx == '0) ? HEADER : (idx == LAST) ? csum : sr[TX_DATA_SIZE-1:0];
`else
    localparam logic [IW-1:0] LAST = IW'(NPAY);

    assign cur_byte = (idx == '0) ? HEADER : sr[TX_DATA_SIZE-1:0];
`endif

    assign issue = (state == ISSUE) & i_next;
    assign last = idx == LAST;
    assign o_busy = ~empty | (state != IDLE);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else state <= next_state;
    end

    // a frame is only started while tx_unit is ready, so a stalled link leaves the FIFO untouched
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = (!empty && i_next) ? LOAD : IDLE;
            LOAD:      next_state = ISSUE;
            ISSUE:     next_state = i_next ? WAIT_LOW : ISSUE;
            WAIT_LOW:  next_state = i_next ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: next_state = i_next ? (last ? IDLE : ISSUE) : WAIT_HIGH;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sr <= '0;
            idx <= '0;
            o_valid <= 1'b0;
            o_data <= '0;
        end else begin
            o_valid <= issue;
            if (pop) begin
                sr <= padded;
                idx <= '0;
            end
            if (issue) begin
                o_data <= cur_byte;
                if (idx != '0) sr <= sr >> TX_DATA_SIZE;
            end
            if (state == WAIT_HIGH && i_next) idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_ch_sampler.sv
// tb_multi_ch_sampler: directed frame vectors plus hand-built decimation, overflow, gate and reset sequences.
module tb_multi_ch_sampler;
`ifdef MULTI_CH_SAMPLER_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct packed {
        logic [13:0] d0;
        logic [13:0] d1;
        logic [5:0][7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gate = 1'b0;
    logic adc_init = 1'b1;
    logic [7:0] decim = 8'd0;
    logic [27:0] data = '0;
    logic tx_rdy = 1'b1;
    logic hold = 1'b0;
    logic hold_val = 1'b1;
    logic next;
    logic [7:0] o_data;
    logic o_valid, o_overflow, o_busy;

    int total = 0;
    int passed = 0;
    int n = 0;
    bit ramp = 1'b0;
    logic [7:0] rx[$];
    vec_t vecs[4];

    assign next = hold ? hold_val : tx_rdy;

    multi_ch_sampler dut (
        .i_clock(clk), .i_reset(rst), .i_data(data), .i_gate(gate), .i_adc_init(adc_init),
        .i_decim(decim), .i_next(next), .o_data(o_data), .o_valid(o_valid),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // tx_unit model: drops ready for one cycle after every strobe
    initial forever begin
        @(negedge clk);
        tx_rdy = !o_valid;
    end

    always @(negedge clk) if (o_valid) rx.push_back(o_data);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        n++;
        if (ramp) data = {14'(n + 100), 14'(n)};
    endtask

    task automatic wait_rx(input int cnt);
        for (int i = 0; i < 2000 && rx.size() < cnt; i++) step();
        chk("rx_count", rx.size(), cnt);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && o_busy; i++) step();
        chk("idle", o_busy, 0);
    endtask

    task automatic chk_ramp_frame(input int f, input int d);
        chk("ramp_hdr", rx[f*NB], 8'hA5);
        chk("ramp_b0", rx[f*NB+1], 8'(d));
        chk("ramp_b2", rx[f*NB+3], 8'(d + 100));
        if (NB == 6) chk("ramp_cs", rx[f*NB+5], 8'(d) ^ 8'(d + 100));
    endtask

    initial begin
        int lat;
        int base;
        bit busy_seen;
        vecs[0] = '{14'h1ABC, 14'h0123, {8'hA5, 8'hBC, 8'h1A, 8'h23, 8'h01, 8'h84}};
        vecs[1] = '{14'h3FFF, 14'h0000, {8'hA5, 8'hFF, 8'h3F, 8'h00, 8'h00, 8'hC0}};
        vecs[2] = '{14'h0000, 14'h3FFF, {8'hA5, 8'h00, 8'h00, 8'hFF, 8'h3F, 8'hC0}};
        vecs[3] = '{14'h2A55, 14'h1234, {8'hA5, 8'h55, 8'h2A, 8'h34, 8'h12, 8'h59}};

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_busy", o_busy, 0);

        // single-tick frames with hand-computed bytes and gate-to-header latency
        for (int v = 0; v < 4; v++) begin
            rx.delete();
            data = {vecs[v].d1, vecs[v].d0};
            gate = 1'b1;
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                step();
                if (i == 1) gate = 1'b0;
                #1;
                if (o_valid) begin
                    lat = i;
                    break;
                end
            end
            chk("latency", lat, 6);
            wait_rx(NB);
            for (int b = 0; b < NB; b++) chk($sformatf("vec%0d_byte%0d", v, b), rx[b], vecs[v].exp[5-b]);
            wait_idle();
        end

        // decimation by 4 over 16 capture cycles: samples at n = 2, 6, 10, 14
        rx.delete();
        decim = 8'd3;
        ramp = 1'b1;
        step();
        n = 0;
        data = {14'd100, 14'd0};
        gate = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) gate = 1'b0;
        end
        wait_rx(4 * NB);
        repeat (30) step();
        chk("decim_count", rx.size(), 4 * NB);
        for (int f = 0; f < 4; f++) chk_ramp_frame(f, 2 + 4 * f);
        wait_idle();

        // gate closes while frame 1 is being sent; the second capture still drains
        rx.delete();
        decim = 8'd7;
        step();
        n = 0;
        data = {14'd100, 14'd0};
        gate = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 11) gate = 1'b0;
        end
        chk("gate_mid_sending", o_busy, 1);
        wait_rx(2 * NB);
        repeat (40) step();
        chk("gate_mid_count", rx.size(), 2 * NB);
        chk_ramp_frame(0, 2);
        chk_ramp_frame(1, 10);
        wait_idle();

        // captures suppressed while ADC not initialised
        rx.delete();
        ramp = 1'b0;
        decim = 8'd0;
        adc_init = 1'b0;
        gate = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            busy_seen |= o_busy;
        end
        chk("noinit_busy", busy_seen, 0);
        chk("noinit_ovf", o_overflow, 0);
        chk("noinit_rx", rx.size(), 0);
        gate = 1'b0;
        repeat (4) step();
        adc_init = 1'b1;

        // reset while waiting for tx_unit to take the third byte
        rx.delete();
        data = {vecs[0].d1, vecs[0].d0};
        gate = 1'b1;
        step();
        gate = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            #1;
            if (rx.size() >= 3) break;
        end
        chk("pre_rst_bytes", rx.size(), 3);
        rst = 1'b1;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ovf", o_overflow, 0);
        repeat (2) step();
        rst = 1'b0;
        base = rx.size();
        repeat (30) step();
        chk("post_rst_silent", rx.size(), base);
        chk("post_rst_busy", o_busy, 0);

        // overflow: tx stalled, 17 back-to-back ticks, the last one dropped
        rx.delete();
        hold = 1'b1;
        hold_val = 1'b0;
        ramp = 1'b1;
        step();
        n = 0;
        data = {14'd100, 14'd0};
        gate = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 17) gate = 1'b0;
            if (i == 18) chk("ovf_before", o_overflow, 0);
            if (i == 19) chk("ovf_after", o_overflow, 1);
        end
        chk("ovf_busy", o_busy, 1);
        repeat (6) step();
        hold = 1'b0;
        wait_rx(16 * NB);
        repeat (40) step();
        chk("ovf_frames", rx.size(), 16 * NB);
        for (int f = 0; f < 16; f++) chk($sformatf("ovf_order%0d", f), rx[f*NB+1], 8'(2 + f));
        chk("ovf_sticky", o_overflow, 1);
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
